// File: rtl/fiber_pe_arbiter.sv
// fiber_pe_arbiter
// ----------------
// Round-robin arbiter that funnels requests from NUM_PE processing elements
// into a single fiberBank port, one transaction at a time.
//
// Flow: IDLE picks a winner and accepts its request in the same cycle.
// ISSUE presents the latched request to the bank until the bank accepts it.
// READ/CONSUME then move to RESP, which passes one response beat from the
// bank straight back to the owning PE.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_pe_request_type       4 bits per PE, one-hot FETCH/READ/WRITE/CONSUME
//   i_pe_addr, i_pe_data    per-PE address / write data
//   i_pe_type_valid         per-PE request valid
//   o_pe_type_ready         per-PE request accept (only the winner, only in IDLE)
//   o_pe_data_o             response data shared by all PEs
//   o_pe_data_o_valid       response valid, one-hot to the owner
//   i_pe_data_o_ready       per-PE response ready
//   o_bank_*                request fields / valid towards the bank
//   i_bank_type_ready       bank request accept
//   i_bank_data_o(_valid)   bank response
//   o_bank_data_o_ready     bank response ready
//   o_busy                  high whenever the FSM is not idle
//   o_owner                 index of the currently granted PE
//   o_err_illegal           one-cycle pulse after accepting a non-one-hot type
module fiber_pe_arbiter #(
    parameter int NUM_PE     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int PE_IDX_W   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [4*NUM_PE-1:0]        i_pe_request_type,
    input  logic [ADDR_WIDTH*NUM_PE-1:0] i_pe_addr,
    input  logic [DATA_WIDTH*NUM_PE-1:0] i_pe_data,
    input  logic [NUM_PE-1:0]          i_pe_type_valid,
    output logic [NUM_PE-1:0]          o_pe_type_ready,
    output logic [DATA_WIDTH-1:0]      o_pe_data_o,
    output logic [NUM_PE-1:0]          o_pe_data_o_valid,
    input  logic [NUM_PE-1:0]          i_pe_data_o_ready,
    output logic [3:0]                 o_bank_request_type,
    output logic [ADDR_WIDTH-1:0]      o_bank_addr,
    output logic [DATA_WIDTH-1:0]      o_bank_data,
    output logic                       o_bank_type_valid,
    input  logic                       i_bank_type_ready,
    input  logic [DATA_WIDTH-1:0]      i_bank_data_o,
    input  logic                       i_bank_data_o_valid,
    output logic                       o_bank_data_o_ready,
    output logic                       o_busy,
    output logic [PE_IDX_W-1:0]        o_owner,
    output logic                       o_err_illegal
);

    localparam logic [3:0] TYPE_READ    = 4'b0010;
    localparam logic [3:0] TYPE_CONSUME = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PE_IDX_W-1:0]     r_rr_ptr;
    logic [PE_IDX_W-1:0]     r_owner;
    logic [3:0]              r_type;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_err_illegal;

    // Per-PE views of the flattened request buses.
    logic [3:0]              w_req_type [NUM_PE];
    logic [ADDR_WIDTH-1:0]   w_req_addr [NUM_PE];
    logic [DATA_WIDTH-1:0]   w_req_data [NUM_PE];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
            assign w_req_type[gi] = i_pe_request_type[4*gi +: 4];
            assign w_req_addr[gi] = i_pe_addr[ADDR_WIDTH*gi +: ADDR_WIDTH];
            assign w_req_data[gi] = i_pe_data[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search starting at r_rr_ptr. NUM_PE is a power of two, so
    // wrap-around falls out of the PE_IDX_W-bit addition.
    logic                    w_found;
    logic [PE_IDX_W-1:0]     w_winner;

    always_comb begin : arb
        logic [PE_IDX_W-1:0] v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            v_idx = r_rr_ptr + PE_IDX_W'(i);
            if (!w_found && i_pe_type_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    logic       w_accept;
    logic [3:0] w_win_type;
    logic       w_win_legal;
    logic       w_resp_type;
    logic       w_resp_done;

    assign w_accept    = (r_state == S_IDLE) && w_found;
    assign w_win_type  = w_req_type[w_winner];
    assign w_win_legal = (w_win_type != 4'd0) && ((w_win_type & (w_win_type - 4'd1)) == 4'd0);
    assign w_resp_type = (r_type == TYPE_READ) || (r_type == TYPE_CONSUME);
    assign w_resp_done = i_bank_data_o_valid && i_pe_data_o_ready[r_owner];

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // An illegal type is consumed here and never reaches the bank.
                if (w_accept && w_win_legal) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (i_bank_type_ready) w_state_next = w_resp_type ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                if (w_resp_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic; response path is a pure pass-through while in RESP.
    always_comb begin
        o_pe_type_ready     = '0;
        o_pe_data_o         = '0;
        o_pe_data_o_valid   = '0;
        o_bank_data_o_ready = 1'b0;
        if (w_accept) o_pe_type_ready[w_winner] = 1'b1;
        if (r_state == S_RESP) begin
            o_pe_data_o                = i_bank_data_o;
            o_pe_data_o_valid[r_owner] = i_bank_data_o_valid;
            o_bank_data_o_ready        = i_pe_data_o_ready[r_owner];
        end
    end

    assign o_bank_type_valid   = (r_state == S_ISSUE);
    assign o_bank_request_type = r_type;
    assign o_bank_addr         = r_addr;
    assign o_bank_data         = r_data;
    assign o_busy              = (r_state != S_IDLE);
    assign o_owner             = r_owner;
    assign o_err_illegal       = r_err_illegal;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_type        <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_err_illegal <= w_accept && !w_win_legal;
            if (w_accept) begin
                r_type   <= w_win_type;
                r_addr   <= w_req_addr[w_winner];
                r_data   <= w_req_data[w_winner];
                r_owner  <= w_winner;
                r_rr_ptr <= w_winner + PE_IDX_W'(1);
            end
        end
    end

endmodule

// File: doc/fiber_pe_arbiter.md
FIBER_PE_ARBITER -- requirements
Module: fiber_pe_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_PE, default 4, number of PE requesters (power of 2, 2..16); DATA_WIDTH, default 16, data word width; ADDR_WIDTH, default 64, address width; PE_IDX_W, default 2, equal to log2(NUM_PE).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_pe_request_type  input  4*NUM_PE  per-PE one-hot type: FETCH=0001, READ=0010, WRITE=0100, CONSUME=1000; PE k uses bits [4k+3:4k].
REQ-006 i_pe_addr  input  ADDR_WIDTH*NUM_PE  per-PE request address.
REQ-007 i_pe_data  input  DATA_WIDTH*NUM_PE  per-PE write data; used only for WRITE.
REQ-008 i_pe_type_valid  input  NUM_PE  per-PE request valid.
REQ-009 o_pe_type_ready  output  NUM_PE  per-PE request accepted.
REQ-010 o_pe_data_o  output  DATA_WIDTH  response data, shared by all PEs.
REQ-011 o_pe_data_o_valid  output  NUM_PE  response valid, one-hot to the owning PE.
REQ-012 i_pe_data_o_ready  input  NUM_PE  per-PE response ready.
REQ-013 o_bank_request_type, o_bank_addr, o_bank_data  output  4 / ADDR_WIDTH / DATA_WIDTH  request fields to fiberBank.
REQ-014 o_bank_type_valid  output  1; i_bank_type_ready  input  1  bank request handshake.
REQ-015 i_bank_data_o  input  DATA_WIDTH; i_bank_data_o_valid  input  1; o_bank_data_o_ready  output  1  bank response handshake.
REQ-016 o_busy  output  1  high in any state other than IDLE.
REQ-017 o_owner  output  PE_IDX_W  index of the PE currently granted.
REQ-018 o_err_illegal  output  1  one-cycle pulse when an accepted type is not one-hot.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and RESP, and SHALL process one transaction at a time.
REQ-020 Arbitration in IDLE: the winner SHALL be the first PE with valid set, searching from rr_ptr upward with wrap from NUM_PE-1 to 0.
REQ-021 In IDLE, o_pe_type_ready[winner] SHALL be asserted combinationally in the same cycle; all other ready bits SHALL be 0.
REQ-022 On that accept edge, the block SHALL register the winner's type, addr and data, set owner=winner, and set rr_ptr=(winner+1) mod NUM_PE.
REQ-023 After the accept edge, the FSM SHALL go to ISSUE; an illegal type SHALL instead pulse o_err_illegal in the next cycle and return to IDLE with nothing sent to the bank.
REQ-024 In ISSUE, o_bank_type_valid SHALL be 1 and the registered fields SHALL be held stable until i_bank_type_ready is seen high on a clock edge.
REQ-025 On bank accept, READ and CONSUME SHALL go to RESP; FETCH and WRITE SHALL go to IDLE.
REQ-026 In RESP: o_pe_data_o=i_bank_data_o; o_pe_data_o_valid[owner]=i_bank_data_o_valid; o_bank_data_o_ready=i_pe_data_o_ready[owner]; all of these are combinational pass-through.
REQ-027 A response SHALL be exactly one beat; the FSM SHALL go to IDLE on the edge where valid and ready are both high.
REQ-028 Outside RESP, o_pe_data_o_valid and o_bank_data_o_ready SHALL be 0, and o_pe_data_o SHALL be 0.
REQ-029 Outside IDLE, o_pe_type_ready SHALL be all zeros; a PE that keeps valid high SHALL stay pending and SHALL NOT be dropped.
REQ-030 Minimum occupancy SHALL be: FETCH/WRITE 2 cycles (IDLE accept, ISSUE with ready=1); READ/CONSUME 3 cycles when the bank and PE respond immediately.
REQ-031 A PE whose valid drops while it is not granted SHALL lose no state.
REQ-032 rr_ptr SHALL advance only on accept, including accept of an illegal type.

Reset
REQ-033 While i_reset is high at a clock edge, the block SHALL enter IDLE with rr_ptr=0, owner=0 and all registered fields=0.
REQ-034 After reset, o_busy, o_err_illegal, o_bank_type_valid, o_pe_data_o_valid and o_bank_data_o_ready SHALL all be 0.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction without completing it, and the next request SHALL be arbitrated starting from PE0.

Verification
REQ-036 PE0 FETCH addr=0x00000000FFFFFFFF, bank ready=1 -> o_bank_request_type=0001 and addr match in cycle 2; o_busy low in cycle 3.
REQ-037 PE2 CONSUME, bank returns 0x0000 and PE2 ready=1 -> o_pe_data_o_valid=0100 and data=0x0000; the FSM returns to IDLE the next cycle.
REQ-038 All 4 PEs issue WRITE with bank ready=1 -> grants are PE0, PE1, PE2, PE3 in order; a second round restarts at PE0.
REQ-039 READ with i_pe_data_o_ready held low for 5 cycles -> o_bank_data_o_ready=0 and the FSM stays in RESP with data stable; completion occurs in the cycle ready rises.
REQ-040 PE1 type=0011 -> o_err_illegal pulses once, o_bank_type_valid never rises, and rr_ptr=2.
REQ-041 i_reset pulsed while in ISSUE -> o_bank_type_valid=0 the next cycle and o_busy=0; a following PE3 request is granted correctly.
